// File: rtl/pll_lmmi_pkg.sv
// Shared types and constants for the PLL LMMI reconfiguration sequencer.
// Includes the register widths, the sequencer states and the read-modify-write merge.
package pll_lmmi_pkg;

    localparam int LMMI_OFFSET_W = 7;
    localparam int LMMI_DATA_W   = 8;

    // LMMI offset of the DIVA output divider register.
    localparam logic [LMMI_OFFSET_W-1:0] DIVA_OFFSET = 7'h12;

    typedef enum logic [2:0] {
        IDLE,
        HOLD,
        RD_REQ,
        RD_WAIT,
        WR_REQ,
        WAIT_LOCK
    } state_t;

    // Bits set in mask take the new value; all other bits keep the register contents.
    function automatic logic [LMMI_DATA_W-1:0] rmw_merge(
        input logic [LMMI_DATA_W-1:0] old_val,
        input logic [LMMI_DATA_W-1:0] mask,
        input logic [LMMI_DATA_W-1:0] new_val
    );
        return (old_val & ~mask) | (new_val & mask);
    endfunction

endpackage

// File: rtl/pll_lock_monitor.sv
// Qualifies the PLL lock after a reconfiguration: 2-flop synchroniser, stable-lock
// counter and timeout counter. Both status outputs are valid only while armed.
module pll_lock_monitor #(
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int TO_W         = 16
) (
    input  logic i_clk,
    input  logic i_rst,
    input  logic i_start,
    input  logic i_pll_lock,
    output logic o_locked,
    output logic o_timeout
);

    logic [1:0]      r_sync;
    logic            r_active;
    logic [TO_W-1:0] r_stable_cnt;
    logic [TO_W-1:0] r_to_cnt;

    logic [TO_W-1:0] w_stable_nxt;
    logic [TO_W-1:0] w_to_nxt;

    assign w_stable_nxt = r_sync[1] ? r_stable_cnt + 1'b1 : '0;
    assign w_to_nxt     = r_to_cnt + 1'b1;

    // Flag in the cycle the count reaches its limit so the FSM registers the pulse on that edge.
    assign o_locked  = r_active && (w_stable_nxt == TO_W'(LOCK_STABLE));
    assign o_timeout = r_active && (w_to_nxt == TO_W'(LOCK_TIMEOUT));

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_sync       <= '0;
            r_active     <= 1'b0;
            r_stable_cnt <= '0;
            r_to_cnt     <= '0;
        end else if (i_start) begin
            // Flush the synchroniser so a lock level sampled before the PLL left reset is never trusted.
            r_sync       <= '0;
            r_active     <= 1'b1;
            r_stable_cnt <= '0;
            r_to_cnt     <= '0;
        end else begin
            r_sync <= {r_sync[0], i_pll_lock};
            if (r_active) begin
                r_stable_cnt <= w_stable_nxt;
                r_to_cnt     <= w_to_nxt;
                if (o_locked || o_timeout) begin
                    r_active <= 1'b0;
                end
            end
        end
    end

endmodule

// File: rtl/pll_lmmi_reconfig_ctrl.sv
// Read-modify-write sequencer for one PLL_CORE over LMMI: hold PLL reset, read the
// register, merge masked bits, write back, release reset and wait for a stable lock.
module pll_lmmi_reconfig_ctrl
    import pll_lmmi_pkg::*;
#(
    parameter int RST_HOLD     = 16,
    parameter int LOCK_STABLE  = 8,
    parameter int LOCK_TIMEOUT = 65535,
    parameter int TO_W         = 16
) (
    input  logic                     i_clk,
    input  logic                     i_rst,
    input  logic                     i_req_valid,
    output logic                     o_req_ready,
    input  logic [LMMI_OFFSET_W-1:0] i_req_offset,
    input  logic [LMMI_DATA_W-1:0]   i_req_mask,
    input  logic [LMMI_DATA_W-1:0]   i_req_data,
    output logic                     o_lmmi_request,
    output logic                     o_lmmi_wr_rdn,
    output logic [LMMI_OFFSET_W-1:0] o_lmmi_offset,
    output logic [LMMI_DATA_W-1:0]   o_lmmi_wdata,
    input  logic                     i_lmmi_ready,
    input  logic [LMMI_DATA_W-1:0]   i_lmmi_rdata,
    input  logic                     i_lmmi_rdata_valid,
    output logic                     o_pll_rst,
    input  logic                     i_pll_lock,
    output logic                     o_busy,
    output logic                     o_done,
    output logic                     o_err,
    output logic [LMMI_DATA_W-1:0]   o_old_data
);

    state_t                 r_state;
    logic [TO_W-1:0]        r_hold_cnt;
    logic [LMMI_DATA_W-1:0] r_mask;
    logic [LMMI_DATA_W-1:0] r_data;

    logic                   w_accept;
    logic [LMMI_DATA_W-1:0] w_merged;
    logic                   w_lock_start;
    logic                   w_locked;
    logic                   w_timeout;

    assign w_accept     = i_req_valid && o_req_ready;
    assign w_merged     = rmw_merge(i_lmmi_rdata, r_mask, r_data);
    assign w_lock_start = (r_state == WR_REQ) && i_lmmi_ready;

    pll_lock_monitor #(
        .LOCK_STABLE  (LOCK_STABLE),
        .LOCK_TIMEOUT (LOCK_TIMEOUT),
        .TO_W         (TO_W)
    ) u_lock_mon (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (w_lock_start),
        .i_pll_lock (i_pll_lock),
        .o_locked   (w_locked),
        .o_timeout  (w_timeout)
    );

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state        <= IDLE;
            r_hold_cnt     <= '0;
            r_mask         <= '0;
            r_data         <= '0;
            o_req_ready    <= 1'b1;
            o_busy         <= 1'b0;
            o_done         <= 1'b0;
            o_err          <= 1'b0;
            o_pll_rst      <= 1'b0;
            o_lmmi_request <= 1'b0;
            o_lmmi_wr_rdn  <= 1'b0;
            o_lmmi_offset  <= '0;
            o_lmmi_wdata   <= '0;
            o_old_data     <= '0;
        end else begin
            o_done <= 1'b0;
            o_err  <= 1'b0;
            case (r_state)
                IDLE: begin
                    if (w_accept) begin
                        // The offset register doubles as the captured request offset.
                        o_lmmi_offset <= i_req_offset;
                        r_mask        <= i_req_mask;
                        r_data        <= i_req_data;
                        r_hold_cnt    <= '0;
                        o_pll_rst     <= 1'b1;
                        o_req_ready   <= 1'b0;
                        o_busy        <= 1'b1;
                        r_state       <= HOLD;
                    end
                end
                HOLD: begin
                    if (r_hold_cnt == TO_W'(RST_HOLD - 1)) begin
                        o_lmmi_request <= 1'b1;
                        o_lmmi_wr_rdn  <= 1'b0;
                        r_state        <= RD_REQ;
                    end else begin
                        r_hold_cnt <= r_hold_cnt + 1'b1;
                    end
                end
                RD_REQ: begin
                    if (i_lmmi_ready) begin
                        o_lmmi_request <= 1'b0;
                        r_state        <= RD_WAIT;
                    end
                end
                RD_WAIT: begin
                    if (i_lmmi_rdata_valid) begin
                        o_old_data     <= i_lmmi_rdata;
                        o_lmmi_wdata   <= w_merged;
                        o_lmmi_request <= 1'b1;
                        o_lmmi_wr_rdn  <= 1'b1;
                        r_state        <= WR_REQ;
                    end
                end
                WR_REQ: begin
                    if (i_lmmi_ready) begin
                        o_lmmi_request <= 1'b0;
                        o_lmmi_wr_rdn  <= 1'b0;
                        o_pll_rst      <= 1'b0;
                        r_state        <= WAIT_LOCK;
                    end
                end
                WAIT_LOCK: begin
                    // A stable lock takes priority over a timeout landing in the same cycle.
                    if (w_locked) begin
                        o_done      <= 1'b1;
                        o_busy      <= 1'b0;
                        o_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end else if (w_timeout) begin
                        o_err       <= 1'b1;
                        o_busy      <= 1'b0;
                        o_req_ready <= 1'b1;
                        r_state     <= IDLE;
                    end
                end
                default: begin
                    o_lmmi_request <= 1'b0;
                    o_pll_rst      <= 1'b0;
                    o_busy         <= 1'b0;
                    o_req_ready    <= 1'b1;
                    r_state        <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/pll_lmmi_reconfig_ctrl.md
Name: pll_lmmi_reconfig_ctrl

Overview:
Run-time reconfiguration sequencer for one PLL_CORE instance (e.g. changing DIVA) through the PLL's LMMI register port. It accepts one read-modify-write request at a time. For each request it holds the PLL in reset, reads the target register, merges the new bits under a mask, writes the result back, releases reset and waits for a stable lock. It sits between the fabric-side clock manager and the PLL_CORE primitive, and it is the only LMMI master for that PLL.

Parameters:
RST_HOLD, 16, cycles pll_rst is held high before the LMMI access starts (minimum 1)
LOCK_STABLE, 8, consecutive cycles pll_lock must be high before the request counts as done (minimum 1)
LOCK_TIMEOUT, 65535, maximum cycles spent in WAIT_LOCK before an error is flagged
TO_W, 16, counter width; must satisfy 2^TO_W > LOCK_TIMEOUT

Ports:
clk  in  1  single clock; LMMI clock is driven from the same net
rst  in  1  synchronous, active-high reset
req_valid  in  1  reconfiguration request
req_ready  out  1  high only in IDLE
req_offset  in  7  LMMI register offset
req_mask  in  8  bits set to 1 are replaced
req_data  in  8  new bit values
lmmi_request  out  1  LMMI transaction request
lmmi_wr_rdn  out  1  1 = write, 0 = read
lmmi_offset  out  7  LMMI offset
lmmi_wdata  out  8  LMMI write data
lmmi_ready  in  1  LMMI accept strobe
lmmi_rdata  in  8  LMMI read data
lmmi_rdata_valid  in  1  read data strobe
pll_rst  out  1  PLL reset, active high
pll_lock  in  1  PLL lock indicator, asynchronous to clk
busy  out  1  high whenever state is not IDLE
done  out  1  one-cycle pulse on successful lock
err  out  1  one-cycle pulse on lock timeout
old_data  out  8  register value read during the last request

Behaviour:
- Reset values: all outputs 0, except req_ready=1; state=IDLE.
- Offset, mask and data are captured when req_valid && req_ready. They stay stable until the request finishes.
- pll_lock passes through a 2-flop synchroniser before any use.

States and transitions:
- IDLE: on accept, set pll_rst=1, clear the counter, go to HOLD.
- HOLD: count RST_HOLD cycles, then go to RD_REQ.
- RD_REQ: lmmi_request=1, wr_rdn=0, offset driven. Hold all three until a cycle with lmmi_ready=1, then go to RD_WAIT.
- RD_WAIT: request=0. On lmmi_rdata_valid, load old_data=lmmi_rdata and load the merged word (rdata & ~mask) | (data & mask). Go to WR_REQ.
- WR_REQ: request=1, wr_rdn=1, wdata=merged word. Leave on lmmi_ready=1; in that same cycle clear pll_rst and go to WAIT_LOCK.
- WAIT_LOCK:
  - The stable counter increments while synced lock=1 and resets to 0 on lock=0.
  - Stable counter reaching LOCK_STABLE: pulse done, go to IDLE.
  - Otherwise, timeout counter reaching LOCK_TIMEOUT: pulse err, go to IDLE.
  - If both conditions hit in the same cycle, done wins.

Rules and boundary conditions:
- On error, pll_rst stays 0; software decides whether to retry.
- lmmi_rdata_valid outside RD_WAIT is ignored.
- lmmi_ready arriving in the same cycle the request is first raised counts as acceptance, so the minimum transaction is 1 cycle.
- Only one LMMI transaction is outstanding at any time.
- rst asserted mid-sequence returns to IDLE next cycle with pll_rst=0 and lmmi_request=0. No partial write is retried; the PLL register may therefore hold either the old or the new value.
- Latency, accept to done, with 0-wait LMMI and the PLL already locked: RST_HOLD + 1 (RD_REQ) + 1 (RD_WAIT, valid next cycle) + 1 (WR_REQ) + 2 (synchroniser) + LOCK_STABLE.

Decomposition:
- Package pll_lmmi_pkg holds:
  - state enum: IDLE, HOLD, RD_REQ, RD_WAIT, WR_REQ, WAIT_LOCK;
  - LMMI_OFFSET_W=7 and LMMI_DATA_W=8;
  - the DIVA register offset constant.
- Sub-module pll_lock_monitor holds the synchroniser, the stable counter and the timeout counter.
  - Inputs: clk, rst, start, pll_lock.
  - Outputs: locked, timeout.

Test Plan:
- Request offset 0x12, mask 0x0F, data 0x05; LMMI model returns 0xA3, ready 0-wait, lock high → write data 0xA5, old_data=0xA3, done exactly at the computed latency with default parameters, err=0.
- LMMI ready delayed 5 cycles on read and 3 on write → lmmi_request, wr_rdn and offset held stable throughout; exactly one read and one write observed; wdata correct.
- pll_lock toggles 1,1,1,0 then stays high → stable counter restarts; done only after 8 consecutive high cycles.
- LOCK_TIMEOUT=100, pll_lock held 0 → err pulses after 100 WAIT_LOCK cycles, pll_rst=0, req_ready=1 the next cycle.
- rst asserted during RD_WAIT → next cycle pll_rst=0, lmmi_request=0, busy=0; a late lmmi_rdata_valid does not change old_data.
- req_valid held high back-to-back → second request accepted only after done; req_ready=0 throughout busy.
